// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Main sequencer for the multi-cycle MIPS datapath. Steps each instruction
//   through fetch / decode / execute / memory / writeback and drives every
//   PC, IR, register-file, ALU-select and memory strobe.
//
// Ports
//   clk, reset     : clock; synchronous active-high reset
//   opcode_i       : IR[31:26], valid from DECODE onward
//   funct_i        : IR[5:0]
//   zero_i         : ALU zero flag (combinational)
//   mem_ready_i    : memory completes the current request this cycle
//   mem_req_o      : memory request strobe
//   mem_we_o       : memory write enable (meaningful only with mem_req_o)
//   iord_o         : memory address select, 0 = PC, 1 = ALUOut
//   ir_write_o     : load IR
//   pc_write_o     : load PC
//   pc_source_o    : 00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a_o    : 0 = PC, 1 = rs
//   alu_src_b_o    : 00 = rt, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op_o       : operation class to ALU control
//   alu_funct_o    : function field to ALU control
//   reg_write_o    : register-file write enable
//   reg_dst_o      : 0 = rt, 1 = rd
//   mem_to_reg_o   : 0 = ALUOut, 1 = MDR
//   illegal_o      : high while in TRAP
//   state_o        : current state, for debug
//
// Memory handshake: the FSM asserts mem_req_o (with mem_we_o / iord_o) and
// holds them stable until a cycle in which mem_ready_i is 1; that cycle
// completes the transfer. mem_ready_i is ignored whenever mem_req_o is 0.
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int STATE_W         = 4,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic [1:0]         pc_source_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [3:0]         alu_op_o,
    output logic [5:0]         alu_funct_o,
    output logic               reg_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        EXEC_R   = STATE_W'(2),
        EXEC_I   = STATE_W'(3),
        MEM_ADDR = STATE_W'(4),
        MEM_RD   = STATE_W'(5),
        MEM_WR   = STATE_W'(6),
        WB_R     = STATE_W'(7),
        WB_I     = STATE_W'(8),
        WB_MEM   = STATE_W'(9),
        BRANCH   = STATE_W'(10),
        JUMP     = STATE_W'(11),
        TRAP     = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_source_o  = 2'b00;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 4'b0000;
        alu_funct_o  = funct_i;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_o    = 1'b0;
        state_o      = state;

        if (reset) begin
            // Reset silences every output, including the debug state and the
            // funct pass-through, and aborts any memory access in flight.
            next_state  = FETCH;
            alu_funct_o = 6'b000000;
            state_o     = '0;
        end else begin
            unique case (state)
                FETCH: begin
                    mem_req_o   = 1'b1;
                    alu_src_b_o = 2'b01;
                    // IR load and PC+4 update only in the completing cycle.
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                    if (mem_ready_i) next_state = DECODE;
                end
                DECODE: begin
                    // ALUOut captures PC + (imm << 2) for a possible branch.
                    alu_src_b_o = 2'b11;
                    unique case (opcode_i)
                        OP_RTYPE:                         next_state = EXEC_R;
                        OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: next_state = EXEC_I;
                        OP_LW, OP_SW:                     next_state = MEM_ADDR;
                        OP_BEQ, OP_BNE:                   next_state = BRANCH;
                        OP_J:                             next_state = JUMP;
                        default: next_state = TRAP_ON_ILLEGAL ? TRAP : FETCH;
                    endcase
                end
                EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 4'b1111;
                    next_state  = WB_R;
                end
                EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    unique case (opcode_i)
                        OP_ORI:  alu_op_o = 4'b0001;
                        OP_LUI:  alu_op_o = 4'b0010;
                        OP_ANDI: alu_op_o = 4'b0011;
                        default: alu_op_o = 4'b0000;
                    endcase
                    next_state = WB_I;
                end
                MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    if (opcode_i == OP_SW) begin
                        alu_op_o   = 4'b0101;
                        next_state = MEM_WR;
                    end else begin
                        alu_op_o   = 4'b0100;
                        next_state = MEM_RD;
                    end
                end
                MEM_RD: begin
                    mem_req_o = 1'b1;
                    iord_o    = 1'b1;
                    if (mem_ready_i) next_state = WB_MEM;
                end
                MEM_WR: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    iord_o    = 1'b1;
                    if (mem_ready_i) next_state = FETCH;
                end
                WB_R: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                    next_state  = FETCH;
                end
                WB_I: begin
                    reg_write_o = 1'b1;
                    next_state  = FETCH;
                end
                WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                    next_state   = FETCH;
                end
                BRANCH: begin
                    // rs - rt sets zero_i; the funct field is forced to SUB.
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 4'b1111;
                    alu_funct_o = 6'b100010;
                    pc_source_o = 2'b01;
                    pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
                    next_state  = FETCH;
                end
                JUMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 2'b10;
                    next_state  = FETCH;
                end
                TRAP: begin
                    illegal_o = 1'b1;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main sequencer for the multi-cycle MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback over several clocks, and drives the shared ALU by producing the {alu_op, function} pair consumed by the ALU control unit. It also produces every PC, IR, register-file and memory strobe, and handshakes with a single shared instruction/data memory port.

Parameters:
STATE_W, 4, width of the state register and of state_o
TRAP_ON_ILLEGAL, 1, 1 = an unknown opcode enters TRAP (sticky); 0 = treat it as a NOP and return to FETCH

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
opcode_i  in  6  IR[31:26], valid from DECODE onward
funct_i  in  6  IR[5:0]
zero_i  in  1  ALU zero flag, combinational from the current ALU result
mem_ready_i  in  1  memory has completed the current request this cycle
mem_req_o  out  1  memory request strobe
mem_we_o  out  1  write enable, valid only while mem_req_o=1
iord_o  out  1  memory address select: 0=PC, 1=ALUOut
ir_write_o  out  1  load IR
pc_write_o  out  1  load PC
pc_source_o  out  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jump target {PC[31:28],IR[25:0],2'b00}
alu_src_a_o  out  1  ALU A operand: 0=PC, 1=rs
alu_src_b_o  out  2  ALU B operand: 00=rt, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
alu_op_o  out  4  operation class to ALU control
alu_funct_o  out  6  function field to ALU control
reg_write_o  out  1  register-file write enable
reg_dst_o  out  1  destination register: 0=rt, 1=rd
mem_to_reg_o  out  1  writeback data: 0=ALUOut, 1=MDR
illegal_o  out  1  high in TRAP
state_o  out  STATE_W  current state, for debug

Behaviour:
- Reset: synchronous. Any cycle with reset=1 forces next state FETCH and holds every output at 0, including mem_req_o. Reset wins over all other events, including mid-memory-access. In the first cycle after reset falls the FSM is in FETCH.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_R=7, WB_I=8, WB_MEM=9, BRANCH=10, JUMP=11, TRAP=12.
- Default outputs are 0 in every state; alu_funct_o defaults to funct_i.
- FETCH:
  - Drives mem_req=1, iord=0, src_a=0, src_b=01, alu_op=0000.
  - Stays in FETCH while mem_ready_i=0.
  - When mem_ready_i=1: ir_write=1 and pc_write=1 with pc_source=00 (PC+4), both Mealy-gated by mem_ready_i; next state DECODE.
- DECODE:
  - Drives src_a=0, src_b=11, alu_op=0000, so ALUOut captures the branch target.
  - Dispatch on opcode_i:
    - 000000 -> EXEC_R
    - 001000 ADDI, 001101 ORI, 001111 LUI, 001100 ANDI -> EXEC_I
    - 100011 LW, 101011 SW -> MEM_ADDR
    - 000100 BEQ, 000101 BNE -> BRANCH
    - 000010 J -> JUMP
    - any other opcode -> TRAP (or FETCH if TRAP_ON_ILLEGAL=0)
- EXEC_R: src_a=1, src_b=00, alu_op=1111, alu_funct=funct_i. Next state WB_R.
- EXEC_I: src_a=1, src_b=10. alu_op is ADDI 0000, ORI 0001, LUI 0010, ANDI 0011. Next state WB_I.
- MEM_ADDR: src_a=1, src_b=10, alu_op=0100 for LW or 0101 for SW. Next state MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, iord=1, we=0. Holds until mem_ready_i=1, then goes to WB_MEM.
- MEM_WR: mem_req=1, iord=1, we=1. Holds until mem_ready_i=1, then goes to FETCH.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- BRANCH:
  - Drives src_a=1, src_b=00, alu_op=1111, alu_funct forced to 100010 (SUB), pc_source=01.
  - pc_write = zero_i for BEQ, ~zero_i for BNE (Mealy).
  - Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- TRAP: illegal_o=1, all strobes 0. The only exit is reset.
- Memory handshake rules:
  - While a request is waiting, mem_req_o, mem_we_o and iord_o stay stable.
  - A mem_ready_i pulse arriving while mem_req_o=0 is ignored.
- Latency with zero wait states: R-type and I-ALU 4 cycles, LW 5, SW 4, BEQ/BNE 3, J 3. Each memory wait cycle adds 1.
- At most one of ir_write, reg_write and (mem_req & we) is high in any cycle.

Test Plan:
- Reset held 3 cycles mid-MEM_RD with mem_ready_i=1 -> all outputs 0 during reset; state_o=0 in the first cycle after release; no reg_write pulse.
- ADD (opcode 000000, funct 100000), mem_ready_i tied 1 -> state_o sequence 0,1,2,7,0; in EXEC_R alu_op=1111 and alu_funct=100000; reg_write=1 with reg_dst=1 only in WB_R.
- LW with FETCH ready delayed 2 cycles and MEM_RD ready delayed 1 -> FETCH lasts 3 cycles and pc_write pulses once; MEM_ADDR shows alu_op=0100; WB_MEM shows mem_to_reg=1; 8 cycles total.
- BEQ with zero_i=1, then BNE with zero_i=1 -> BEQ: pc_write=1 and pc_source=01 in BRANCH with alu_funct=100010; BNE: pc_write=0; both return to FETCH after 3 cycles.
- ORI, LUI, ANDI back-to-back -> EXEC_I shows alu_op 0001, 0010, 0011 respectively, each followed by WB_I with reg_dst=0.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 -> TRAP (state_o=12), illegal_o stays 1 for 20+ cycles with mem_ready_i toggling; reset returns the FSM to FETCH. With TRAP_ON_ILLEGAL=0 -> DECODE goes to FETCH and illegal_o stays 0.
